// File: rtl/led_bin2seg.sv
// Binary -> BCD (iterative double-dabble) -> 7-segment patterns; result BIN_W+1 cycles after accept.
// in_ready only in IDLE; in_valid while busy is ignored, nothing queued; led_out held between updates.
module led_bin2seg #(
    parameter int   NUM          = 4,
    parameter int   BIN_W        = 14,
    parameter logic VALID_SIGNAL = 1'b0,
    parameter int   BLANK_LZ     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIN_W-1:0]   in_data,
    input  logic [NUM-1:0]     in_dp,
    output logic [NUM*8-1:0]   led_out,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    localparam int               CNT_W   = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10**NUM - 1);
    localparam logic [7:0]       INV     = {8{~VALID_SIGNAL}};

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [NUM*4-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM-1:0]     dp_q, dp_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [NUM*8-1:0]   led_q, led_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [NUM*4-1:0]   bcd_adj;
    logic [NUM*8-1:0]   enc;
    logic [3:0]         nib;
    logic [7:0]         pat;
    logic               lz;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h40;
        endcase
    endfunction

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Scan from the most significant digit so lz tracks "this and all higher digits are zero".
    always_comb begin
        lz  = 1'b1;
        nib = '0;
        pat = '0;
        enc = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            nib    = bcd_q[4*i +: 4];
            lz     = lz && (nib == 4'd0);
            pat    = ((BLANK_LZ != 0) && lz && (i > 0)) ? 8'h00 : seg7(nib);
            pat[7] = dp_q[i];
            if (ovf_pend_q)
                pat = 8'h40;
            enc[8*i +: 8] = pat ^ INV;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dp_d       = dp_q;
        ovf_pend_d = ovf_pend_q;
        led_d      = led_q;
        ovf_d      = ovf_q;
        done_d     = (state_q == ENCODE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d      = in_data;
                    dp_d       = in_dp;
                    ovf_pend_d = (in_data > MAX_VAL);
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[NUM*4-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_END)
                    state_d = ENCODE;
            end
            ENCODE: begin
                led_d   = enc;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dp_q       <= '0;
            ovf_pend_q <= 1'b0;
            led_q      <= {NUM{INV}};
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dp_q       <= dp_d;
            ovf_pend_q <= ovf_pend_d;
            led_q      <= led_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign led_out  = led_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_led_bin2seg.sv
// Directed checks of led_bin2seg: reset, conversions, blanking, dp, overflow, busy input, reset abort.
module tb_led_bin2seg;

    localparam int NUM   = 4;
    localparam int BIN_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BIN_W-1:0]  in_data;
    logic [NUM-1:0]    in_dp;
    logic [NUM*8-1:0]  led_out;
    logic              busy;
    logic              done;
    logic              ovf;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_led = 32'hFFFF_FFFF;

    led_bin2seg #(
        .NUM          (NUM),
        .BIN_W        (BIN_W),
        .VALID_SIGNAL (1'b0),
        .BLANK_LZ     (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dp    (in_dp),
        .led_out  (led_out),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Accept at edge T, expect result exactly at edge T+15.
    task automatic convert(input string tag, input logic [BIN_W-1:0] data, input logic [NUM-1:0] dp,
                           input logic [31:0] exp_led, input logic exp_ovf);
        wait_ready(tag);
        in_data  = data;
        in_dp    = dp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (14) @(posedge clk);
        #1;
        check({tag, "_early_done"}, 32'(done), 32'd0);
        check({tag, "_stable"}, led_out, last_led);
        @(posedge clk); #1;
        check({tag, "_led"}, led_out, exp_led);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_ready_at_done"}, 32'(in_ready), 32'd1);
        last_led = exp_led;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit seen_done;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dp    = '0;
        #1;
        check("rst_led", led_out, 32'hFFFF_FFFF);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        convert("v1234", 14'd1234, 4'b0000, 32'hF9A4_B099, 1'b0);
        convert("v0",    14'd0,    4'b0000, 32'hFFFF_FFC0, 1'b0);
        convert("v9999", 14'd9999, 4'b0000, 32'h9090_9090, 1'b0);
        convert("v7dp",  14'd7,    4'b0010, 32'hFFFF_7FF8, 1'b0);
        convert("v10000",14'd10000,4'b1111, 32'hBFBF_BFBF, 1'b1);
        convert("v42",   14'd42,   4'b0000, 32'hFFFF_99A4, 1'b0);

        // Held in_valid: second value taken on the first in_ready cycle after done.
        wait_ready("hold");
        in_data  = 14'd1234;
        in_dp    = 4'b0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 14'd56;
        repeat (14) @(posedge clk);
        #1;
        check("hold_early_done", 32'(done), 32'd0);
        check("hold_stable", led_out, last_led);
        @(posedge clk); #1;
        check("hold_first_led", led_out, 32'hF9A4_B099);
        check("hold_first_done", 32'(done), 32'd1);
        check("hold_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_second_busy", 32'(busy), 32'd1);
        repeat (14) @(posedge clk);
        #1;
        check("hold_second_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("hold_second_led", led_out, 32'hFFFF_9282);
        check("hold_second_done", 32'(done), 32'd1);
        last_led = 32'hFFFF_9282;

        // Reset during SHIFT aborts the conversion.
        wait_ready("abort");
        in_data  = 14'd9999;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_led", led_out, 32'hFFFF_FFFF);
        check("abort_busy", 32'(busy), 32'd0);
        in_data  = 14'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("rst_vs_valid_busy", 32'(busy), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_led_held", led_out, 32'hFFFF_FFFF);
        last_led = 32'hFFFF_FFFF;
        @(posedge clk); #1;

        convert("v42_again", 14'd42, 4'b0000, 32'hFFFF_99A4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_bin2seg.md
Name: led_bin2seg

Overview:
Upstream feeder for led_display_ctrl. Accepts a binary value over a valid/ready handshake and converts it to BCD with an iterative double-dabble engine. Encodes each BCD digit to a 7-segment pattern, with optional leading-zero blanking and per-digit decimal points. Drives a registered NUM×8 pattern bus that connects directly to led_display_ctrl's led_in and stays stable between updates.

Parameters:
NUM, 4, number of digits; matches led_display_ctrl NUM.
BIN_W, 14, input binary width; must satisfy 2^BIN_W > 10^NUM - 1.
VALID_SIGNAL, 1'b0, segment-on level; matches led_display_ctrl VALID_SIGNAL (0 = active-low).
BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/in_dp valid
in_ready  output  1  block can accept; equals (state==IDLE)
in_data  input  BIN_W  unsigned value to display
in_dp  input  NUM  decimal-point mask; bit i lights dp of digit i
led_out  output  NUM*8  segment patterns; digit i at [8i+7:8i]; digit 0 = least significant
busy  output  1  conversion in progress (state != IDLE)
done  output  1  one-cycle pulse when led_out updates
ovf  output  1  last accepted value exceeded 10^NUM - 1; held until next update

Behaviour:
- Segment bit map, active-high form: bit0=a … bit6=g, bit7=dp. Digits 0-9 map to 3F 06 5B 4F 66 6D 7D 07 7F 6F. Blank is 00. Dash is 40.
- If VALID_SIGNAL=0, every output bit is inverted from the active-high form.
- Reset (async, rst=1): state=IDLE, led_out = all segments off (all-1 when VALID_SIGNAL=0), busy=0, done=0, ovf=0. in_ready=1 while in IDLE.
- FSM states: IDLE, SHIFT, ENCODE.
  - IDLE: on in_valid && in_ready, latch in_data into the shift register, in_dp into the dp register, and compute the overflow flag (in_data > 10^NUM-1). Clear BCD register and bit counter. Go to SHIFT.
  - SHIFT: exactly BIN_W cycles. Each cycle, for each of the NUM BCD nibbles, add 3 if the nibble is >= 5. Then shift {bcd, bin} left by 1. Go to ENCODE when the counter reaches BIN_W-1.
  - ENCODE: one cycle. Register the new led_out, update ovf, pulse done. Return to IDLE.
- Latency: handshake accepted at clock edge T → led_out/done valid after edge T+BIN_W+1. in_ready returns to 1 in the same cycle done is high. For BIN_W=14, the result appears 15 cycles after acceptance.
- Throughput: one conversion per BIN_W+2 cycles. in_valid while busy is ignored and nothing is queued; the source must hold its data until the handshake.
- Leading-zero blanking (BLANK_LZ=1): digit i (i>0) is blank if it and all higher digits are 0. Digit 0 is never blanked, so value 0 displays "0".
- Decimal point: in_dp[i] sets bit7 of digit i even when the digit is blanked.
- Overflow: all digits show dash, in_dp is ignored, ovf=1. The BCD result is discarded.
- led_out changes only in ENCODE or on reset. There are no glitches while busy.
- rst during SHIFT/ENCODE aborts the conversion: led_out is blanked and the FSM returns to IDLE. No done pulse is produced.
- in_valid and rst asserted together: reset wins and the input is not accepted.

Test Plan:
(NUM=4, BIN_W=14, VALID_SIGNAL=0, BLANK_LZ=1)
1. Reset → led_out=32'hFFFFFFFF, in_ready=1, busy=0, ovf=0, done=0.
2. in_data=1234, in_dp=0 → exactly 15 cycles after acceptance: led_out=32'hF9A4B099, done high one cycle, ovf=0.
3. in_data=0 → led_out=32'hFFFFFFC0. in_data=9999 → led_out=32'h90909090.
4. in_data=7, in_dp=4'b0010 → led_out=32'hFFFF7FF8 (blank digit1 shows dp only).
5. in_data=10000, in_dp=4'b1111 → led_out=32'hBFBFBFBF, ovf=1. Then in_data=42 → led_out=32'hFFFF99A4, ovf=0.
6. Hold in_valid with new data during busy → ignored; only the first value is displayed, and the second is accepted on the first in_ready=1 cycle. Assert rst at SHIFT cycle 5 → led_out=all-1, no done pulse, in_ready=1 after release.
